gon_drain: RTL and testbench
============================

GON_DRAIN -- requirements
Module: gon_drain

Interface
REQ-001 Parameter ROW_LEN, default 4, width of row tag.
REQ-002 Parameter ID_LEN, default 5, width of column tag.
REQ-003 Parameter VALUE_LEN, default 32, width of psum value.
REQ-004 Parameter ADDR_LEN, default 16, width of write address.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse; begins a drain pass when idle.
REQ-008 abort  in  1  synchronous cancel of the current pass.
REQ-009 num_rows  in  ROW_LEN  rows to drain; sampled on accepted start.
REQ-010 num_cols  in  ID_LEN  columns per row; sampled on accepted start.
REQ-011 base_addr  in  ADDR_LEN  first write address; sampled on accepted start.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  one-cycle pulse at end of pass.
REQ-014 err_spurious  out  1  sticky flag: enable seen while ready low.
REQ-015 ready  out  1  GON request; tags valid while high.
REQ-016 row_tag  out  ROW_LEN  target row of request.
REQ-017 col_tag  out  ID_LEN  target column of request.
REQ-018 enable  in  1  GON response valid.
REQ-019 value  in  VALUE_LEN  GON response data.
REQ-020 wr_en  out  1  buffer write strobe.
REQ-021 wr_addr  out  ADDR_LEN  buffer write address.
REQ-022 wr_data  out  VALUE_LEN  buffer write data.
REQ-023 wr_stall  in  1  buffer backpressure; write not taken while high.

Function
REQ-024 States: IDLE, REQ, DRAIN, DONE.
REQ-025 IDLE: start accepted only here; start in other states is ignored.
REQ-026 start with num_rows==0 or num_cols==0 goes IDLE->DONE with no requests or writes.
REQ-027 Otherwise IDLE->REQ with row=0, col=0, addr=base_addr.
REQ-028 Order: row-major, col inner; col wraps num_cols-1 -> 0 and row increments.
REQ-029 REQ: ready high with row_tag/col_tag = current counters, tags stable until handshake.
REQ-030 Handshake completes in a cycle where ready && enable; enable may arrive the same cycle ready rises or any later cycle.
REQ-031 On handshake value is latched into a one-entry holding register with current addr; counters and addr (+1) advance next cycle.
REQ-032 ready deasserts while holding register is full and wr_stall is high; ready reasserts the cycle after the register empties.
REQ-033 Holding register drives wr_en/wr_addr/wr_data registered; entry retires on wr_en && !wr_stall; simultaneous retire and new handshake is allowed (full throughput 1 value/cycle).
REQ-034 Handshake on last element (row=num_rows-1, col=num_cols-1) moves REQ->DRAIN; ready low in DRAIN.
REQ-035 DRAIN->DONE when holding register empty.
REQ-036 DONE: done=1 for one cycle, busy=0, then IDLE.
REQ-037 abort in REQ or DRAIN: next cycle IDLE, ready=0, wr_en=0, holding entry discarded, no done pulse.
REQ-038 enable while ready low sets err_spurious; value ignored; cleared only by reset or accepted start.
REQ-039 addr arithmetic is modulo 2^ADDR_LEN (wraps silently).
REQ-040 Latency start->first ready: 1 cycle; handshake->wr_en: 1 cycle.

Reset
REQ-041 rst low asynchronously forces IDLE, counters 0, holding register empty.
REQ-042 Reset values: busy=0, done=0, err_spurious=0, ready=0, row_tag=0, col_tag=0, wr_en=0, wr_addr=0, wr_data=0.
REQ-043 Reset mid-pass drops all pending data; no write issued after release until new start.

Structure
REQ-044 FSM state encoding and default tag widths (ROW_LEN, ID_LEN, VALUE_LEN) live in the shared pe_array package.
REQ-045 Holding register with retire logic is one sub-module, gon_drain_hold.

Verification
REQ-046 num_rows=2, num_cols=3, base=0x10, enable tied high, no stall -> tags (0,0)..(1,2) one per cycle, writes 0x10..0x15 with matching values, one done pulse.
REQ-047 num_rows=1, num_cols=2, enable 3 cycles late per request -> tags held stable each wait, 2 writes, done after second write.
REQ-048 num_rows=1, num_cols=4, wr_stall high 5 cycles after first handshake -> ready low while full, no lost or duplicated data, addr sequence contiguous.
REQ-049 num_cols=0 start -> done pulse 2 cycles after start, ready and wr_en never high.
REQ-050 abort after 2nd handshake of 3x3 pass -> IDLE next cycle, no done, new start runs clean from base.
REQ-051 enable pulse while IDLE -> err_spurious=1 and stays 1 until next accepted start; rst low mid-pass -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pe_array_pkg.sv
// ----------------------------------------------------------------------------
// pe_array_pkg
// Shared definitions for the PE-array drain logic.
//   - Default widths for row tags, column tags, psum values and write addresses.
//   - State encoding for the gon_drain pass controller.
// ----------------------------------------------------------------------------
package pe_array_pkg;

  localparam int ROW_LEN_DEF   = 4;
  localparam int ID_LEN_DEF    = 5;
  localparam int VALUE_LEN_DEF = 32;
  localparam int ADDR_LEN_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/gon_drain_hold.sv
// ----------------------------------------------------------------------------
// gon_drain_hold
// One-entry holding register between the GON response and the psum buffer.
// The entry is presented as a registered write and retires when the buffer
// does not stall. A load in the same cycle as a retire replaces the entry,
// which is what allows one value per cycle.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_load, i_load_addr/data  capture a new entry (GON handshake)
//   i_flush                   discard the entry (abort); wins over i_load
//   i_stall                   buffer backpressure
//   o_full                    entry valid
//   o_wr_en/addr/data         buffer write port
// ----------------------------------------------------------------------------
module gon_drain_hold
  import pe_array_pkg::*;
#(
  parameter int ADDR_LEN  = ADDR_LEN_DEF,
  parameter int VALUE_LEN = VALUE_LEN_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic [ADDR_LEN-1:0]  i_load_addr,
  input  logic [VALUE_LEN-1:0] i_load_data,
  input  logic                 i_flush,
  input  logic                 i_stall,
  output logic                 o_full,
  output logic                 o_wr_en,
  output logic [ADDR_LEN-1:0]  o_wr_addr,
  output logic [VALUE_LEN-1:0] o_wr_data
);

  logic                 r_full;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [VALUE_LEN-1:0] r_data;
  logic                 w_retire;

  assign w_retire = r_full && !i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      // Caller only loads when the entry is empty or retiring this cycle.
      r_full <= 1'b1;
      r_addr <= i_load_addr;
      r_data <= i_load_data;
    end else if (w_retire) begin
      r_full <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_wr_en   = r_full;
  assign o_wr_addr = r_addr;
  assign o_wr_data = r_data;

endmodule

// File: rtl/gon_drain.sv
// ----------------------------------------------------------------------------
// gon_drain
// Drains a num_rows x num_cols block of partial sums from the GON, one
// request per element in row-major order, and writes each returned value to
// consecutive buffer addresses starting at base_addr (wrapping modulo
// 2^ADDR_LEN).
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   i_start, i_abort                   begin pass (idle only) / cancel pass
//   i_num_rows, i_num_cols, i_base_addr pass shape, sampled on accepted start
//   o_busy, o_done, o_err_spurious     status (done is a one-cycle pulse)
//   o_ready, o_row_tag, o_col_tag      GON request
//   i_enable, i_value                  GON response
//   o_wr_en, o_wr_addr, o_wr_data      buffer write port
//   i_wr_stall                         buffer backpressure
// ----------------------------------------------------------------------------
module gon_drain
  import pe_array_pkg::*;
#(
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int ID_LEN    = ID_LEN_DEF,
  parameter int VALUE_LEN = VALUE_LEN_DEF,
  parameter int ADDR_LEN  = ADDR_LEN_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [ROW_LEN-1:0]   i_num_rows,
  input  logic [ID_LEN-1:0]    i_num_cols,
  input  logic [ADDR_LEN-1:0]  i_base_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err_spurious,
  output logic                 o_ready,
  output logic [ROW_LEN-1:0]   o_row_tag,
  output logic [ID_LEN-1:0]    o_col_tag,
  input  logic                 i_enable,
  input  logic [VALUE_LEN-1:0] i_value,
  output logic                 o_wr_en,
  output logic [ADDR_LEN-1:0]  o_wr_addr,
  output logic [VALUE_LEN-1:0] o_wr_data,
  input  logic                 i_wr_stall
);

  drain_state_t         r_state;
  logic [ROW_LEN-1:0]   r_row;
  logic [ID_LEN-1:0]    r_col;
  logic [ADDR_LEN-1:0]  r_addr;
  logic [ROW_LEN-1:0]   r_num_rows;
  logic [ID_LEN-1:0]    r_num_cols;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_full;
  logic w_ready;
  logic w_hs;
  logic w_abort_act;
  logic w_last_col;
  logic w_last;
  logic w_start_ok;

  assign w_start_ok  = (r_state == ST_IDLE) && i_start;
  assign w_abort_act = i_abort && ((r_state == ST_REQ) || (r_state == ST_DRAIN));

  // Ready drops combinationally when the entry is stuck behind a stall, so a
  // handshake can never land on an entry that cannot retire this cycle.
  assign w_ready = (r_state == ST_REQ) && !(w_full && i_wr_stall);
  assign w_hs    = w_ready && i_enable && !w_abort_act;

  assign w_last_col = (r_col == (r_num_cols - ID_LEN'(1)));
  assign w_last     = w_last_col && (r_row == (r_num_rows - ROW_LEN'(1)));

  gon_drain_hold #(
    .ADDR_LEN  (ADDR_LEN),
    .VALUE_LEN (VALUE_LEN)
  ) u_hold (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_hs),
    .i_load_addr (r_addr),
    .i_load_data (i_value),
    .i_flush     (w_abort_act),
    .i_stall     (i_wr_stall),
    .o_full      (w_full),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data)
  );

  // Pass controller. done/busy are registered on the way out of DONE, so the
  // done pulse coincides with busy falling.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_num_rows <= '0;
      r_num_cols <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_num_rows <= i_num_rows;
            r_num_cols <= i_num_cols;
            r_row      <= '0;
            r_col      <= '0;
            r_addr     <= i_base_addr;
            r_busy     <= 1'b1;
            if ((i_num_rows == '0) || (i_num_cols == '0)) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (w_abort_act) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_hs) begin
            r_addr <= r_addr + ADDR_LEN'(1);
            if (w_last) begin
              r_state <= ST_DRAIN;
            end else if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + ROW_LEN'(1);
            end else begin
              r_col <= r_col + ID_LEN'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (w_abort_act) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (!w_full) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky protocol error: a response with no request outstanding. A new
  // accepted start clears it so each pass reports its own errors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_err <= 1'b0;
    end else if (i_enable && !w_ready) begin
      r_err <= 1'b1;
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err_spurious = r_err;
  assign o_ready        = w_ready;
  assign o_row_tag      = r_row;
  assign o_col_tag      = r_col;

endmodule

// File: tb/tb_gon_drain.sv
// ----------------------------------------------------------------------------
// tb_gon_drain
// Self-checking bench for gon_drain. The reference model is the list of
// expected buffer writes: element k of a pass goes to base+k with whatever
// value the GON returned for request k, and the one-entry holding register is
// the set of handshaken-but-not-yet-written elements.
// ----------------------------------------------------------------------------
module tb_gon_drain;

  localparam int RL = 4;
  localparam int IL = 5;
  localparam int VL = 32;
  localparam int AL = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [RL-1:0] num_rows;
  logic [IL-1:0] num_cols;
  logic [AL-1:0] base_addr;
  logic          busy;
  logic          done;
  logic          err_spurious;
  logic          ready;
  logic [RL-1:0] row_tag;
  logic [IL-1:0] col_tag;
  logic          enable;
  logic [VL-1:0] value;
  logic          wr_en;
  logic [AL-1:0] wr_addr;
  logic [VL-1:0] wr_data;
  logic          wr_stall;

  always #5 clk = ~clk;

  gon_drain #(
    .ROW_LEN   (RL),
    .ID_LEN    (IL),
    .VALUE_LEN (VL),
    .ADDR_LEN  (AL)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_num_rows     (num_rows),
    .i_num_cols     (num_cols),
    .i_base_addr    (base_addr),
    .o_busy         (busy),
    .o_done         (done),
    .o_err_spurious (err_spurious),
    .o_ready        (ready),
    .o_row_tag      (row_tag),
    .o_col_tag      (col_tag),
    .i_enable       (enable),
    .i_value        (value),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .i_wr_stall     (wr_stall)
  );

  typedef struct {
    logic [AL-1:0] a;
    logic [VL-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},    busy, 0);
    check({tag, ".done"},    done, 0);
    check({tag, ".err"},     err_spurious, 0);
    check({tag, ".ready"},   ready, 0);
    check({tag, ".row_tag"}, row_tag, 0);
    check({tag, ".col_tag"}, col_tag, 0);
    check({tag, ".wr_en"},   wr_en, 0);
    check({tag, ".wr_addr"}, wr_addr, 0);
    check({tag, ".wr_data"}, wr_data, 0);
  endtask

  // Idle cycles: nothing may be requested, written or signalled.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      start = 1'b0; abort = 1'b0; enable = 1'b0; wr_stall = 1'b0;
      #1;
      check({tag, ".q_ready"}, ready, 0);
      check({tag, ".q_wr_en"}, wr_en, 0);
      check({tag, ".q_done"},  done, 0);
      check({tag, ".q_busy"},  busy, 0);
      @(negedge clk);
    end
  endtask

  // One drain pass acting as GON responder and buffer. stall_mode: 0 none,
  // 1 random, 2 five cycles right after the first handshake. Enable waits a
  // random dmin..dmax ready-cycles per request. abort_after>0 cancels once
  // that many handshakes have completed.
  task automatic run_pass(input int r, input int c, input logic [AL-1:0] base,
                          input int stall_mode, input int dmin, input int dmax,
                          input int abort_after, input string tag);
    int total = r * c;
    int k = 0;
    int waited = 0;
    int dly;
    int first_hs = -1;
    int cyc = 0;
    bit seen_done = 1'b0;
    bit aborted = 1'b0;
    bit exp_ready;
    bit retire;
    logic [AL-1:0] ea;
    logic [VL-1:0] v;
    exp_q.delete();
    num_rows = RL'(r); num_cols = IL'(c); base_addr = base; start = 1'b1;
    @(negedge clk);
    dly = $urandom_range(dmax, dmin);
    while (!seen_done && !aborted && cyc < 400) begin
      start = 1'b0; abort = 1'b0; enable = 1'b0;
      case (stall_mode)
        0:       wr_stall = 1'b0;
        1:       wr_stall = ($urandom_range(2, 0) == 0);
        default: wr_stall = (first_hs >= 0) && (cyc > first_hs) && (cyc <= first_hs + 5);
      endcase
      #1;
      exp_ready = (k < total) && !(wr_stall && exp_q.size() != 0);
      check({tag, ".ready"}, ready, exp_ready);
      check({tag, ".wr_en"}, wr_en, exp_q.size() != 0);
      check({tag, ".err"}, err_spurious, 0);
      check({tag, ".hold_depth"}, exp_q.size() <= 1, 1);
      if (wr_en && exp_q.size() != 0) begin
        check({tag, ".wr_addr"}, wr_addr, exp_q[0].a);
        check({tag, ".wr_data"}, wr_data, exp_q[0].d);
      end
      retire = wr_en && !wr_stall && (exp_q.size() != 0);
      if (done) begin
        seen_done = 1'b1;
        check({tag, ".done_count"}, k, total);
        check({tag, ".done_pending"}, exp_q.size(), 0);
        check({tag, ".done_busy"}, busy, 0);
      end else begin
        check({tag, ".busy"}, busy, 1);
      end
      if (abort_after != 0 && k == abort_after) begin
        abort = 1'b1;
        aborted = 1'b1;
      end else if (exp_ready) begin
        check({tag, ".row_tag"}, row_tag, k / c);
        check({tag, ".col_tag"}, col_tag, k % c);
        if (waited >= dly) begin
          v = $urandom;
          value = v;
          enable = 1'b1;
          ea = base + AL'(k);
          exp_q.push_back('{a: ea, d: v});
          if (first_hs < 0) first_hs = cyc;
          k++;
          waited = 0;
          dly = $urandom_range(dmax, dmin);
        end else begin
          waited++;
        end
        // Start while busy must be ignored, whatever the shape inputs say.
        if (k < total && $urandom_range(5, 0) == 0) begin
          start = 1'b1;
          num_rows = RL'($urandom);
          num_cols = IL'($urandom);
          base_addr = AL'($urandom);
        end
      end
      if (retire) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    if (aborted) begin
      exp_q.delete();
    end else begin
      check({tag, ".done_seen"}, seen_done, 1);
    end
    quiet(3, tag);
  endtask

  // Degenerate shape: done two cycles after start with no request or write.
  task automatic run_empty(input int r, input int c, input string tag);
    num_rows = RL'(r); num_cols = IL'(c); base_addr = 16'h1234; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check({tag, ".c1_done"},  done, 0);
    check({tag, ".c1_busy"},  busy, 1);
    check({tag, ".c1_ready"}, ready, 0);
    check({tag, ".c1_wr_en"}, wr_en, 0);
    @(negedge clk);
    #1;
    check({tag, ".c2_done"},  done, 1);
    check({tag, ".c2_busy"},  busy, 0);
    check({tag, ".c2_ready"}, ready, 0);
    check({tag, ".c2_wr_en"}, wr_en, 0);
    @(negedge clk);
    quiet(2, tag);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; enable = 1'b0; wr_stall = 1'b0;
    num_rows = '0; num_cols = '0; base_addr = '0; value = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check_all_zero("reset_released");
    @(negedge clk);

    run_pass(2, 3, 16'h0010, 0, 0, 0, 0, "basic_2x3");
    run_pass(1, 2, 16'h0200, 0, 3, 3, 0, "late_enable");
    run_pass(1, 4, 16'h0300, 2, 0, 0, 0, "stall_window");
    run_empty(3, 0, "zero_cols");
    run_empty(0, 4, "zero_rows");
    run_pass(3, 3, 16'h0040, 0, 0, 0, 2, "abort_3x3");
    run_pass(3, 3, 16'h0040, 0, 0, 0, 0, "after_abort");
    run_pass(2, 2, 16'hFFFE, 1, 0, 2, 0, "addr_wrap");
    for (int i = 0; i < 8; i++) begin
      run_pass($urandom_range(4, 1), $urandom_range(5, 1), AL'($urandom),
               1, 0, 2, 0, $sformatf("rand%0d", i));
    end

    // Spurious response while idle: sticky until the next accepted start.
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    #1;
    check("spurious.set", err_spurious, 1);
    @(negedge clk);
    #1;
    check("spurious.sticky", err_spurious, 1);
    @(negedge clk);
    run_pass(1, 1, 16'h0500, 0, 0, 0, 0, "spurious_clear");

    // Reset in the middle of a pass with the holding register full.
    num_rows = 3; num_cols = 3; base_addr = 16'h0080; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    enable = 1'b1;
    value = 32'hDEAD_BEEF;
    @(negedge clk);
    @(negedge clk);
    enable = 1'b0;
    #1;
    check("midpass.wr_en_before", wr_en, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midpass_reset");
    @(negedge clk);
    rst_n = 1'b1;
    quiet(5, "post_reset");
    check("post_reset.err", err_spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
